// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: drains the TX FIFO one byte per frame and serialises it LSB first.
// Optional even-parity bit between data and stop bits is compiled in with UART_TX_PARITY_EN.

module uart_tx_ctrl #(
  parameter int DataBits = 8,
  parameter int StopBits = 1,
  parameter int DivWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [DivWidth-1:0] baud_div_i,
  input  logic                fifo_empty_i,
  input  logic [DataBits-1:0] fifo_rd_data_i,
  output logic                fifo_rd_en_o,
  output logic                tx_o,
  output logic                busy_o,
  output logic                frame_done_o
);

  localparam int IdxWidth = $clog2(DataBits);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_e;
`endif

  state_e                state_q, state_d;
  logic [DataBits-1:0]   shift_q, shift_d;
  logic [DivWidth-1:0]   div_q, div_d;
  logic [DivWidth-1:0]   cnt_q, cnt_d;
  logic [IdxWidth-1:0]   idx_q, idx_d;
  logic                  stop_q, stop_d;
  logic                  tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  logic bit_end;

  assign bit_end = (cnt_q == '0);
  assign tx_o    = tx_q;
  assign busy_o  = (state_q != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // tx is registered, so each bit value is loaded on the same edge that enters its state
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    div_d        = div_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    stop_d       = stop_q;
    tx_d         = tx_q;
`ifdef UART_TX_PARITY_EN
    par_d        = par_q;
`endif
    fifo_rd_en_o = 1'b0;
    frame_done_o = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty_i) begin
          fifo_rd_en_o = !rst_i;
          state_d      = FETCH;
        end
      end

      FETCH: begin
        shift_d = fifo_rd_data_i;
`ifdef UART_TX_PARITY_EN
        par_d   = ^fifo_rd_data_i;
`endif
        div_d   = (baud_div_i == '0) ? DivWidth'(1) : baud_div_i;
        cnt_d   = div_d - 1'b1;
        idx_d   = '0;
        stop_d  = 1'b0;
        tx_d    = 1'b0;
        state_d = START;
      end

      START: begin
        if (bit_end) begin
          cnt_d   = div_q - 1'b1;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_d = div_q - 1'b1;
          if (idx_q == IdxWidth'(DataBits - 1)) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_d   = div_q - 1'b1;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif

      STOP: begin
        if (bit_end) begin
          if (stop_q == 1'(StopBits - 1)) begin
            frame_done_o = 1'b1;
            state_d      = IDLE;
          end else begin
            stop_d = 1'b1;
            cnt_d  = div_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Testbench for uart_tx_ctrl: FIFO model plus a per-cycle expected-waveform queue built from each fetched byte.
// Build with UART_TX_PARITY_EN to match a parity-enabled DUT.

module tb_uart_tx_ctrl;

  localparam int DataBits = 8;
  localparam int StopBits = 1;
  localparam int DivWidth = 16;
`ifdef UART_TX_PARITY_EN
  localparam int ParityBits = 1;
`else
  localparam int ParityBits = 0;
`endif
  localparam int FrameBits = 1 + DataBits + ParityBits + StopBits;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [DivWidth-1:0] baud_div_i;
  logic                fifo_empty_i;
  logic [DataBits-1:0] fifo_rd_data_i;
  logic                fifo_rd_en_o;
  logic                tx_o;
  logic                busy_o;
  logic                frame_done_o;

  always #5 clk_i = ~clk_i;

  uart_tx_ctrl #(
    .DataBits(DataBits),
    .StopBits(StopBits),
    .DivWidth(DivWidth)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .baud_div_i    (baud_div_i),
    .fifo_empty_i  (fifo_empty_i),
    .fifo_rd_data_i(fifo_rd_data_i),
    .fifo_rd_en_o  (fifo_rd_en_o),
    .tx_o          (tx_o),
    .busy_o        (busy_o),
    .frame_done_o  (frame_done_o)
  );

  typedef struct packed {
    logic tx;
    logic done;
  } line_t;

  line_t      line_q[$];
  logic [7:0] fifo_q[$];
  int         len_q[$];
  bit         fetch_pend;
  logic [7:0] fetch_byte;
  bit         check_en;
  int tests, failed, cyc;
  int hi_run, last_gap, low_run, last_low, done_cnt, rd_cnt, rd_cyc;
  logic prev_tx;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected line level for every cycle of one frame, starting at the start bit
  task automatic buildFrame(input logic [7:0] b, input int d);
    logic  bits[$];
    line_t e;
    bits.push_back(1'b0);
    for (int i = 0; i < DataBits; i++) bits.push_back(b[i]);
    if (ParityBits == 1) bits.push_back(^b);
    for (int i = 0; i < StopBits; i++) bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int k = 0; k < d; k++) begin
        e.tx   = bits[i];
        e.done = 1'b0;
        line_q.push_back(e);
      end
    end
    e = line_q.pop_back();
    e.done = 1'b1;
    line_q.push_back(e);
  endtask

  task automatic checkCycle();
    line_t e;
    logic  exp_rd, exp_busy;
    int    d;
    exp_rd   = !rst_i && !fetch_pend && (line_q.size() == 0) && !fifo_empty_i;
    exp_busy = fetch_pend || (line_q.size() != 0);
    if (line_q.size() != 0) e = line_q.pop_front();
    else begin
      e.tx   = 1'b1;
      e.done = 1'b0;
    end
    checkOutput("rd_en", fifo_rd_en_o, exp_rd);
    checkOutput("busy", busy_o, exp_busy);
    checkOutput("tx", tx_o, e.tx);
    checkOutput("frame_done", frame_done_o, e.done);

    if (tx_o === 1'b0 && prev_tx === 1'b1) last_gap = hi_run;
    hi_run  = (tx_o === 1'b1) ? hi_run + 1 : 0;
    prev_tx = tx_o;
    if (busy_o === 1'b1 && low_run > 0) last_low = low_run;
    low_run = (busy_o === 1'b1) ? 0 : low_run + 1;
    if (frame_done_o === 1'b1) begin
      done_cnt++;
      len_q.push_back(cyc - rd_cyc - 1);
    end
    if (fifo_rd_en_o === 1'b1) begin
      rd_cnt++;
      rd_cyc = cyc;
    end

    if (fetch_pend) begin
      d = (baud_div_i == 0) ? 1 : int'(baud_div_i);
      buildFrame(fetch_byte, d);
      fetch_pend = 1'b0;
    end
    if (exp_rd) begin
      fetch_pend = 1'b1;
      fetch_byte = fifo_q[0];
    end
    if (rst_i) begin
      line_q.delete();
      fetch_pend = 1'b0;
    end
  endtask

  task automatic step();
    logic rd;
    @(negedge clk_i);
    cyc++;
    if (check_en) checkCycle();
    rd = fifo_rd_en_o;
    @(posedge clk_i);
    #1;
    if (rd === 1'b1 && fifo_q.size() > 0) fifo_rd_data_i = fifo_q.pop_front();
    fifo_empty_i = (fifo_q.size() == 0);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_empty_i = 1'b0;
  endtask

  task automatic runUntilIdle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (busy_o === 1'b0 && fifo_empty_i && line_q.size() == 0 && !fetch_pend) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("idle_reached", ok, 1);
  endtask

  initial begin
    int base, n;
    tests = 0; failed = 0; cyc = 0;
    hi_run = 0; last_gap = 0; low_run = 0; last_low = 0;
    done_cnt = 0; rd_cnt = 0; rd_cyc = 0; prev_tx = 1'b1;
    fetch_pend = 1'b0; fetch_byte = '0; check_en = 1'b0;
    rst_i = 1'b1; baud_div_i = 16'd4; fifo_empty_i = 1'b1; fifo_rd_data_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check_en = 1'b1;

    applyStimulus(8'h3C);
    repeat (3) step();
    checkOutput("rst_no_read", rd_cnt, 0);
    rst_i = 1'b0;
    step();
    checkOutput("first_read", rd_cnt, 1);
    runUntilIdle(200);

    baud_div_i = 16'd4;
    base = done_cnt;
    applyStimulus(8'hA5);
    runUntilIdle(200);
    checkOutput("a5_done", done_cnt - base, 1);
    checkOutput("a5_len", len_q[len_q.size()-1], FrameBits * 4);

    baud_div_i = 16'd2;
    base = rd_cnt;
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    runUntilIdle(200);
    checkOutput("b2b_reads", rd_cnt - base, 2);
    checkOutput("b2b_gap", last_gap, StopBits * 2 + 2);
    checkOutput("b2b_busy_low", last_low, 1);

    baud_div_i = 16'd8;
    applyStimulus(8'h5A);
    repeat (20) step();
    baud_div_i = 16'd3;
    applyStimulus(8'hC3);
    runUntilIdle(400);
    checkOutput("div8_len", len_q[len_q.size()-2], FrameBits * 8);
    checkOutput("div3_len", len_q[len_q.size()-1], FrameBits * 3);
    baud_div_i = 16'd0;
    applyStimulus(8'h81);
    runUntilIdle(200);
    checkOutput("div0_len", len_q[len_q.size()-1], FrameBits);

    baud_div_i = 16'd4;
    base = done_cnt;
    n = rd_cnt;
    applyStimulus(8'hE6);
    for (int i = 0; i < 10 && rd_cnt == n; i++) step();
    checkOutput("abort_read", rd_cnt - n, 1);
    repeat (19) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    step();
    checkOutput("abort_no_done", done_cnt - base, 0);
    applyStimulus(8'h6B);
    runUntilIdle(200);
    checkOutput("after_abort_done", done_cnt - base, 1);

`ifdef UART_TX_PARITY_EN
    baud_div_i = 16'd2;
    applyStimulus(8'h07);
    runUntilIdle(200);
    checkOutput("parity_len", len_q[len_q.size()-1], 22);
`endif

    for (int it = 0; it < 40; it++) begin
      baud_div_i = 16'($urandom_range(0, 5));
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) applyStimulus(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 15)) step();
      if ($urandom_range(0, 1) == 1) baud_div_i = 16'($urandom_range(0, 6));
      runUntilIdle(2000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
